// File: rtl/sdrc_wb_arb.sv
// N-port classic Wishbone front end for sdrc_core: arbitrates masters onto a single app_req
// interface with one access in flight, per-port ack/err pulses and a per-access timeout.
module sdrc_wb_arb #(
    parameter int NP       = 2,
    parameter int APP_AW   = 26,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int TO_CYC   = 1023
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NP-1:0]        wb_cyc_i,
    input  logic [NP-1:0]        wb_stb_i,
    input  logic [NP-1:0]        wb_we_i,
    input  logic [NP*APP_AW-1:0] wb_addr_i,
    input  logic [NP*DW-1:0]     wb_dat_i,
    input  logic [NP*DW/8-1:0]   wb_sel_i,
    output logic [NP*DW-1:0]     wb_dat_o,
    output logic [NP-1:0]        wb_ack_o,
    output logic [NP-1:0]        wb_err_o,
    output logic [NP-1:0]        grant_o,
    input  logic                 sdr_init_done,
    output logic                 app_req,
    output logic [APP_AW-1:0]    app_req_addr,
    output logic [8:0]           app_req_len,
    output logic                 app_req_wr_n,
    input  logic                 app_req_ack,
    output logic [DW-1:0]        app_wr_data,
    output logic [DW/8-1:0]      app_wr_en_n,
    input  logic                 app_wr_next_req,
    input  logic                 app_rd_valid,
    input  logic [DW-1:0]        app_rd_data,
    input  logic                 app_last_rd
);

    localparam int SW = DW / 8;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int TW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {IDLE, REQ, WR, RD, ACK} state_t;

    state_t          state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   rr_ptr;
    logic [TW-1:0]   to_cnt;
    logic            we_q;
    logic [SW-1:0]   sel_q;
    logic [NP-1:0]   pend;
    logic [PW-1:0]   win;
    logic            win_vld;
    logic            unused_last_rd;

    assign app_req_len    = 9'd1;
    assign unused_last_rd = app_last_rd;

    // A port that was just acked/errored still shows stb this cycle; it is not a new request.
    assign pend = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);

    function automatic logic [NP-1:0] onehot(input logic [PW-1:0] g);
        logic [NP-1:0] r;
        r    = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] g);
        if (int'(g) >= NP - 1)
            return '0;
        return g + PW'(1);
    endfunction

    always_comb begin
        int idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        if (ARB_MODE == 1) begin
            for (int k = NP - 1; k >= 0; k--) begin
                if (pend[k]) begin
                    win     = PW'(k);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NP)
                    idx = idx - NP;
                if (!win_vld && pend[idx]) begin
                    win     = PW'(idx);
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            owner        <= '0;
            rr_ptr       <= '0;
            to_cnt       <= '0;
            grant_o      <= '0;
            app_req      <= 1'b0;
            app_req_wr_n <= 1'b1;
            app_wr_en_n  <= '1;
            app_req_addr <= '0;
            app_wr_data  <= '0;
            wb_ack_o     <= '0;
            wb_err_o     <= '0;
            wb_dat_o     <= '0;
        end else begin
            wb_ack_o <= '0;
            wb_err_o <= '0;
            case (state)
                IDLE: begin
                    // Arbitrate only once the previous ack/err pulse has cleared, so a master
                    // holding stb across the ack competes on equal terms with the others.
                    if (sdr_init_done && win_vld && ((wb_ack_o | wb_err_o) == '0)) begin
                        owner        <= win;
                        grant_o      <= onehot(win);
                        app_req_addr <= {2'b00, wb_addr_i[int'(win)*APP_AW + 2 +: APP_AW-2]};
                        app_req_wr_n <= ~wb_we_i[win];
                        app_wr_data  <= wb_dat_i[int'(win)*DW +: DW];
                        we_q         <= wb_we_i[win];
                        sel_q        <= wb_sel_i[int'(win)*SW +: SW];
                        app_req      <= 1'b1;
                        to_cnt       <= '0;
                        state        <= REQ;
                    end
                end
                ACK: begin
                    if (wb_cyc_i[owner])
                        wb_ack_o <= onehot(owner);
                    grant_o <= '0;
                    rr_ptr  <= ptr_next(owner);
                    state   <= IDLE;
                end
                default: begin
                    if (to_cnt == TW'(TO_CYC - 1)) begin
                        app_req     <= 1'b0;
                        app_wr_en_n <= '1;
                        grant_o     <= '0;
                        rr_ptr      <= ptr_next(owner);
                        if (wb_cyc_i[owner])
                            wb_err_o <= onehot(owner);
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        case (state)
                            REQ: begin
                                if (app_req_ack) begin
                                    app_req <= 1'b0;
                                    if (we_q) begin
                                        app_wr_en_n <= ~sel_q;
                                        state       <= WR;
                                    end else begin
                                        state <= RD;
                                    end
                                end
                            end
                            WR: begin
                                if (app_wr_next_req) begin
                                    app_wr_en_n <= '1;
                                    state       <= ACK;
                                end
                            end
                            RD: begin
                                if (app_rd_valid) begin
                                    wb_dat_o[int'(owner)*DW +: DW] <= app_rd_data;
                                    state <= ACK;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdrc_wb_arb.sv
// Directed bench for sdrc_wb_arb: a round-robin instance with controllable app-side responses
// and a fixed-priority instance whose app side always answers immediately.
module tb_sdrc_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        init;
    logic [1:0]  cyc, stb, we;
    logic [51:0] addr;
    logic [63:0] dat;
    logic [7:0]  sel;
    logic [31:0] rd_data;
    logic        auto_next, auto_valid;

    logic [63:0] dat_o_rr, dat_o_fp;
    logic [1:0]  ack_rr, err_rr, grant_rr, ack_fp, err_fp, grant_fp;
    logic        app_req_rr, wr_n_rr, app_req_fp, wr_n_fp;
    logic [25:0] addr_rr, addr_fp;
    logic [8:0]  len_rr, len_fp;
    logic [31:0] wr_data_rr, wr_data_fp;
    logic [3:0]  en_n_rr, en_n_fp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdrc_wb_arb #(.NP(2), .APP_AW(26), .DW(32), .ARB_MODE(0), .TO_CYC(15)) dut_rr (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o_rr),
        .wb_ack_o(ack_rr), .wb_err_o(err_rr), .grant_o(grant_rr), .sdr_init_done(init),
        .app_req(app_req_rr), .app_req_addr(addr_rr), .app_req_len(len_rr),
        .app_req_wr_n(wr_n_rr), .app_req_ack(app_req_rr), .app_wr_data(wr_data_rr),
        .app_wr_en_n(en_n_rr), .app_wr_next_req(auto_next), .app_rd_valid(auto_valid),
        .app_rd_data(rd_data), .app_last_rd(auto_valid)
    );

    sdrc_wb_arb #(.NP(2), .APP_AW(26), .DW(32), .ARB_MODE(1), .TO_CYC(15)) dut_fp (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_addr_i(addr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o_fp),
        .wb_ack_o(ack_fp), .wb_err_o(err_fp), .grant_o(grant_fp), .sdr_init_done(init),
        .app_req(app_req_fp), .app_req_addr(addr_fp), .app_req_len(len_fp),
        .app_req_wr_n(wr_n_fp), .app_req_ack(app_req_fp), .app_wr_data(wr_data_fp),
        .app_wr_en_n(en_n_fp), .app_wr_next_req(1'b1), .app_rd_valid(1'b1),
        .app_rd_data(rd_data), .app_last_rd(1'b1)
    );

    task automatic set_port(input int k, input logic w, input logic [25:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        addr[k*26 +: 26] = a;
        dat[k*32 +: 32]  = d;
        sel[k*4 +: 4]    = s;
        we[k]            = w;
        cyc[k]           = 1'b1;
        stb[k]           = 1'b1;
    endtask

    task automatic drop_port(input int k);
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = '0;
        stb = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        init = 1'b0;
        do_reset();
        total++; if (grant_rr !== 2'b00) begin bad++; $display("FAIL rst_grant got=%h exp=0", grant_rr); end
        total++; if (app_req_rr !== 1'b0) begin bad++; $display("FAIL rst_app_req got=%b exp=0", app_req_rr); end
        total++; if (wr_n_rr !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b exp=1", wr_n_rr); end
        total++; if (en_n_rr !== 4'hF) begin bad++; $display("FAIL rst_en_n got=%h exp=f", en_n_rr); end
        total++; if (addr_rr !== 26'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", addr_rr); end
        total++; if (wr_data_rr !== 32'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=0", wr_data_rr); end
        total++; if ((ack_rr | err_rr) !== 2'b00) begin bad++; $display("FAIL rst_ack_err got=%h/%h exp=0", ack_rr, err_rr); end
        total++; if (dat_o_rr !== 64'h0) begin bad++; $display("FAIL rst_dat_o got=%h exp=0", dat_o_rr); end
        total++; if (len_rr !== 9'd1) begin bad++; $display("FAIL req_len got=%0d exp=1", len_rr); end
    endtask

    task automatic test_init_gate();
        int n;
        bit got;
        set_port(0, 1'b0, 26'h1234, 32'h0, 4'hF);
        rd_data = 32'hDEAD_BEEF;
        repeat (5) @(negedge clk);
        total++; if (app_req_rr !== 1'b0 || grant_rr !== 2'b00) begin
            bad++; $display("FAIL init_gate app_req=%b grant=%h exp 0/0", app_req_rr, grant_rr);
        end
        init = 1'b1;
        n = 0;
        while (n < 2 && app_req_rr !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        total++; if (app_req_rr !== 1'b1) begin bad++; $display("FAIL init_req got=%b exp=1 within 2 cycles", app_req_rr); end
        total++; if (addr_rr !== 26'h48D) begin bad++; $display("FAIL init_addr got=%h exp=48d", addr_rr); end
        total++; if (wr_n_rr !== 1'b1 || grant_rr !== 2'b01) begin
            bad++; $display("FAIL init_rd wr_n=%b grant=%h exp 1/01", wr_n_rr, grant_rr);
        end
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_rr[0]) begin got = 1; break; end
        end
        drop_port(0);
        total++; if (!got) begin bad++; $display("FAIL init_ack got=none exp=ack0"); end
        total++; if (dat_o_rr[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL init_rdata got=%h exp=deadbeef", dat_o_rr[31:0]); end
        @(negedge clk);
    endtask

    task automatic test_write();
        int a1, a0;
        set_port(1, 1'b1, 26'h100, 32'hA5A5_5A5A, 4'b0011);
        for (int i = 0; i < 10; i++) begin
            if (app_req_rr === 1'b1) break;
            @(negedge clk);
        end
        total++; if (addr_rr !== 26'h40) begin bad++; $display("FAIL wr_addr got=%h exp=40", addr_rr); end
        total++; if (wr_n_rr !== 1'b0 || grant_rr !== 2'b10) begin
            bad++; $display("FAIL wr_req wr_n=%b grant=%h exp 0/10", wr_n_rr, grant_rr);
        end
        total++; if (wr_data_rr !== 32'hA5A5_5A5A) begin bad++; $display("FAIL wr_data got=%h exp=a5a55a5a", wr_data_rr); end
        total++; if (en_n_rr !== 4'hF) begin bad++; $display("FAIL wr_en_n_req got=%h exp=f", en_n_rr); end
        @(negedge clk);
        total++; if (en_n_rr !== 4'b1100) begin bad++; $display("FAIL wr_en_n got=%b exp=1100", en_n_rr); end
        a1 = 0; a0 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_rr[1]) begin a1++; drop_port(1); end
            if (ack_rr[0]) a0++;
        end
        total++; if (a1 != 1 || a0 != 0) begin bad++; $display("FAIL wr_acks got=%0d/%0d exp=1/0", a1, a0); end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq[8];
        logic [1:0] prev;
        int n;
        do_reset();
        set_port(0, 1'b0, 26'h10, 32'h0, 4'hF);
        set_port(1, 1'b0, 26'h20, 32'h0, 4'hF);
        n = 0; prev = 2'b00;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (grant_rr != 2'b00 && prev == 2'b00 && n < 8) begin seq[n] = grant_rr; n++; end
            prev = grant_rr;
        end
        drop_port(0); drop_port(1);
        total++; if (n < 4) begin bad++; $display("FAIL rr_count got=%0d exp>=4", n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL rr_seq[%0d] got=%h exp=%h", i, seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_fixed_prio();
        logic [1:0] prev;
        int n, p1;
        bit got;
        do_reset();
        set_port(0, 1'b0, 26'h10, 32'h0, 4'hF);
        set_port(1, 1'b0, 26'h20, 32'h0, 4'hF);
        n = 0; p1 = 0; prev = 2'b00;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (grant_fp != 2'b00 && prev == 2'b00) begin
                n++;
                if (grant_fp !== 2'b01) p1++;
            end
            prev = grant_fp;
        end
        total++; if (n < 4 || p1 != 0) begin bad++; $display("FAIL fp_port0 grants=%0d others=%0d exp>=4/0", n, p1); end
        drop_port(0);
        got = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (grant_fp === 2'b10) begin got = 1; break; end
        end
        drop_port(1);
        total++; if (!got) begin bad++; $display("FAIL fp_port1 got=none exp=grant 10"); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n, acks;
        bit got;
        do_reset();
        auto_valid = 1'b0;
        set_port(0, 1'b0, 26'h200, 32'h0, 4'hF);
        set_port(1, 1'b0, 26'h300, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (app_req_rr === 1'b1) break;
        end
        n = 0; acks = 0;
        while (n < 40 && err_rr[0] !== 1'b1) begin
            @(negedge clk);
            n++;
            if (ack_rr != 2'b00) acks++;
        end
        drop_port(0);
        auto_valid = 1'b1;
        rd_data = 32'h1357_9BDF;
        total++; if (n != 15) begin bad++; $display("FAIL to_latency got=%0d exp=15", n); end
        total++; if (acks != 0) begin bad++; $display("FAIL to_noack got=%0d exp=0", acks); end
        @(negedge clk);
        total++; if (err_rr !== 2'b00) begin bad++; $display("FAIL to_pulse got=%h exp=0", err_rr); end
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (grant_rr === 2'b10) begin got = 1; break; end
            @(negedge clk);
        end
        total++; if (!got) begin bad++; $display("FAIL to_next_grant got=%h exp=10", grant_rr); end
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_rr[1]) begin got = 1; break; end
        end
        drop_port(1);
        total++; if (!got || dat_o_rr[63:32] !== 32'h1357_9BDF) begin
            bad++; $display("FAIL to_port1_rd ack=%b data=%h exp=1/13579bdf", got, dat_o_rr[63:32]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        bit got;
        auto_next = 1'b0;
        set_port(0, 1'b1, 26'h400, 32'h1122_3344, 4'hF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (app_req_rr === 1'b1) break;
        end
        @(negedge clk);
        total++; if (en_n_rr !== 4'h0) begin bad++; $display("FAIL mid_wr_en_n got=%h exp=0", en_n_rr); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (grant_rr !== 2'b00 || app_req_rr !== 1'b0 || wr_n_rr !== 1'b1) begin
            bad++; $display("FAIL mid_rst_ctl grant=%h req=%b wr_n=%b exp 0/0/1", grant_rr, app_req_rr, wr_n_rr);
        end
        total++; if (en_n_rr !== 4'hF || addr_rr !== 26'h0 || wr_data_rr !== 32'h0) begin
            bad++; $display("FAIL mid_rst_app en_n=%h addr=%h data=%h exp f/0/0", en_n_rr, addr_rr, wr_data_rr);
        end
        total++; if (ack_rr !== 2'b00 || err_rr !== 2'b00 || dat_o_rr !== 64'h0) begin
            bad++; $display("FAIL mid_rst_wb ack=%h err=%h dat=%h exp 0/0/0", ack_rr, err_rr, dat_o_rr);
        end
        auto_next = 1'b1;
        rd_data = 32'hCAFE_F00D;
        set_port(0, 1'b0, 26'h404, 32'h0, 4'hF);
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack_rr[0]) begin got = 1; break; end
        end
        drop_port(0);
        total++; if (!got || dat_o_rr[31:0] !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL mid_rd ack=%b data=%h exp=1/cafef00d", got, dat_o_rr[31:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; init = 1'b0;
        cyc = '0; stb = '0; we = '0; addr = '0; dat = '0; sel = '0;
        rd_data = '0; auto_next = 1'b1; auto_valid = 1'b1;
        test_reset();
        test_init_gate();
        test_write();
        test_round_robin();
        test_fixed_prio();
        test_timeout();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
